// File: rtl/core_axi_master.sv
// AXI4-Lite initiator: turns one core-side valid/ready request into a single
// AXI4-Lite read or write transaction and returns the result as a response.
module core_axi_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 16
) (
    input  logic                              CCLK,
    input  logic                              CRST,

    input  logic                              CREQ_VALID,
    output logic                              CREQ_READY,
    input  logic                              CREQ_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CREQ_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CREQ_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CREQ_WSTRB,

    output logic                              CRESP_VALID,
    input  logic                              CRESP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     CRESP_RDATA,
    output logic [1:0]                        CRESP_ERR,
    output logic                              CBUSY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic          r_creqReady;
    logic          r_cbusy;
    logic          r_crespValid;
    logic [DW-1:0] r_crespRdata;
    logic [1:0]    r_crespErr;
    logic [AW-1:0] r_awAddr;
    logic          r_awValid;
    logic [DW-1:0] r_wData;
    logic [SW-1:0] r_wStrb;
    logic          r_wValid;
    logic          r_bReady;
    logic [AW-1:0] r_arAddr;
    logic          r_arValid;
    logic          r_rReady;
    logic          r_awDone;
    logic          r_wDone;

    logic          w_creqReadyNext;
    logic          w_crespValidNext;
    logic [DW-1:0] w_crespRdataNext;
    logic [1:0]    w_crespErrNext;
    logic [AW-1:0] w_awAddrNext;
    logic          w_awValidNext;
    logic [DW-1:0] w_wDataNext;
    logic [SW-1:0] w_wStrbNext;
    logic          w_wValidNext;
    logic          w_bReadyNext;
    logic [AW-1:0] w_arAddrNext;
    logic          w_arValidNext;
    logic          w_rReadyNext;
    logic          w_awDoneNext;
    logic          w_wDoneNext;

    logic          w_reqAccept;
    logic          w_awHs;
    logic          w_wHs;
    logic          w_bHs;
    logic          w_arHs;
    logic          w_rHs;
    logic          w_respHs;
    logic          w_awDoneNow;
    logic          w_wDoneNow;
    logic [AW-1:0] w_alignedAddr;

    assign w_reqAccept   = (r_state == S_IDLE) && CREQ_VALID && r_creqReady;
    assign w_awHs        = r_awValid && M_AXI_AWREADY;
    assign w_wHs         = r_wValid && M_AXI_WREADY;
    assign w_bHs         = M_AXI_BVALID && r_bReady;
    assign w_arHs        = r_arValid && M_AXI_ARREADY;
    assign w_rHs         = M_AXI_RVALID && r_rReady;
    assign w_respHs      = r_crespValid && CRESP_READY;
    assign w_awDoneNow   = r_awDone || w_awHs;
    assign w_wDoneNow    = r_wDone || w_wHs;
    assign w_alignedAddr = CREQ_ADDR & ALIGN_MASK;

    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_reqAccept) begin
                    w_stateNext = CREQ_WRITE ? S_WRITE : S_RADDR;
                end
            end
            S_WRITE: begin
                if (w_awDoneNow && w_wDoneNow) begin
                    w_stateNext = S_WRESP;
                end
            end
            S_WRESP: begin
                if (w_bHs) begin
                    w_stateNext = S_RESP;
                end
            end
            S_RADDR: begin
                if (w_arHs) begin
                    w_stateNext = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_rHs) begin
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                if (w_respHs) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Next values of every registered output; anything not touched holds,
    // which is what keeps VALIDs and payloads stable until their handshake.
    always_comb begin
        w_creqReadyNext  = r_creqReady;
        w_crespValidNext = r_crespValid;
        w_crespRdataNext = r_crespRdata;
        w_crespErrNext   = r_crespErr;
        w_awAddrNext     = r_awAddr;
        w_awValidNext    = r_awValid;
        w_wDataNext      = r_wData;
        w_wStrbNext      = r_wStrb;
        w_wValidNext     = r_wValid;
        w_bReadyNext     = r_bReady;
        w_arAddrNext     = r_arAddr;
        w_arValidNext    = r_arValid;
        w_rReadyNext     = r_rReady;
        w_awDoneNext     = r_awDone;
        w_wDoneNext      = r_wDone;
        unique case (r_state)
            S_IDLE: begin
                if (w_reqAccept) begin
                    w_creqReadyNext = 1'b0;
                    if (CREQ_WRITE) begin
                        w_awAddrNext  = w_alignedAddr;
                        w_wDataNext   = CREQ_WDATA;
                        w_wStrbNext   = CREQ_WSTRB;
                        w_awValidNext = 1'b1;
                        w_wValidNext  = 1'b1;
                        w_awDoneNext  = 1'b0;
                        w_wDoneNext   = 1'b0;
                    end else begin
                        w_arAddrNext  = w_alignedAddr;
                        w_arValidNext = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (w_awHs) begin
                    w_awValidNext = 1'b0;
                    w_awDoneNext  = 1'b1;
                end
                if (w_wHs) begin
                    w_wValidNext = 1'b0;
                    w_wDoneNext  = 1'b1;
                end
                if (w_awDoneNow && w_wDoneNow) begin
                    w_bReadyNext = 1'b1;
                end
            end
            S_WRESP: begin
                if (w_bHs) begin
                    w_crespErrNext   = M_AXI_BRESP;
                    w_crespRdataNext = '0;
                    w_bReadyNext     = 1'b0;
                    w_crespValidNext = 1'b1;
                end
            end
            S_RADDR: begin
                if (w_arHs) begin
                    w_arValidNext = 1'b0;
                    w_rReadyNext  = 1'b1;
                end
            end
            S_RDATA: begin
                if (w_rHs) begin
                    w_crespRdataNext = M_AXI_RDATA;
                    w_crespErrNext   = M_AXI_RRESP;
                    w_rReadyNext     = 1'b0;
                    w_crespValidNext = 1'b1;
                end
            end
            S_RESP: begin
                if (w_respHs) begin
                    w_crespValidNext = 1'b0;
                    w_creqReadyNext  = 1'b1;
                end
            end
            default: begin
                w_creqReadyNext = 1'b1;
            end
        endcase
    end

    // Reset abandons any transfer; slaves share this reset source.
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_creqReady  <= 1'b1;
            r_cbusy      <= 1'b0;
            r_crespValid <= 1'b0;
            r_crespRdata <= '0;
            r_crespErr   <= 2'b00;
            r_awAddr     <= '0;
            r_awValid    <= 1'b0;
            r_wData      <= '0;
            r_wStrb      <= '0;
            r_wValid     <= 1'b0;
            r_bReady     <= 1'b0;
            r_arAddr     <= '0;
            r_arValid    <= 1'b0;
            r_rReady     <= 1'b0;
            r_awDone     <= 1'b0;
            r_wDone      <= 1'b0;
        end else begin
            r_creqReady  <= w_creqReadyNext;
            r_cbusy      <= (w_stateNext != S_IDLE);
            r_crespValid <= w_crespValidNext;
            r_crespRdata <= w_crespRdataNext;
            r_crespErr   <= w_crespErrNext;
            r_awAddr     <= w_awAddrNext;
            r_awValid    <= w_awValidNext;
            r_wData      <= w_wDataNext;
            r_wStrb      <= w_wStrbNext;
            r_wValid     <= w_wValidNext;
            r_bReady     <= w_bReadyNext;
            r_arAddr     <= w_arAddrNext;
            r_arValid    <= w_arValidNext;
            r_rReady     <= w_rReadyNext;
            r_awDone     <= w_awDoneNext;
            r_wDone      <= w_wDoneNext;
        end
    end

    assign CREQ_READY    = r_creqReady;
    assign CBUSY         = r_cbusy;
    assign CRESP_VALID   = r_crespValid;
    assign CRESP_RDATA   = r_crespRdata;
    assign CRESP_ERR     = r_crespErr;
    assign M_AXI_AWADDR  = r_awAddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awValid;
    assign M_AXI_WDATA   = r_wData;
    assign M_AXI_WSTRB   = r_wStrb;
    assign M_AXI_WVALID  = r_wValid;
    assign M_AXI_BREADY  = r_bReady;
    assign M_AXI_ARADDR  = r_arAddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arValid;
    assign M_AXI_RREADY  = r_rReady;

endmodule

// File: tb/tb_core_axi_master.sv
// Directed bench for core_axi_master: the slave side is driven by hand, one
// cycle at a time, and every output is compared against hand-computed values.
module tb_core_axi_master;

    logic        CCLK;
    logic        CRST;
    logic        CREQ_VALID;
    logic        CREQ_READY;
    logic        CREQ_WRITE;
    logic [15:0] CREQ_ADDR;
    logic [31:0] CREQ_WDATA;
    logic [3:0]  CREQ_WSTRB;
    logic        CRESP_VALID;
    logic        CRESP_READY;
    logic [31:0] CRESP_RDATA;
    logic [1:0]  CRESP_ERR;
    logic        CBUSY;
    logic [15:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [15:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int checks   = 0;
    int failures = 0;
    int awBeats  = 0;
    int wBeats   = 0;
    int arBeats  = 0;

    core_axi_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(16)
    ) dut (
        .CCLK(CCLK), .CRST(CRST),
        .CREQ_VALID(CREQ_VALID), .CREQ_READY(CREQ_READY), .CREQ_WRITE(CREQ_WRITE),
        .CREQ_ADDR(CREQ_ADDR), .CREQ_WDATA(CREQ_WDATA), .CREQ_WSTRB(CREQ_WSTRB),
        .CRESP_VALID(CRESP_VALID), .CRESP_READY(CRESP_READY),
        .CRESP_RDATA(CRESP_RDATA), .CRESP_ERR(CRESP_ERR), .CBUSY(CBUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    // Beat counters let us prove each transfer issues exactly one AW/W/AR.
    always @(posedge CCLK) begin
        if (!CRST) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) awBeats++;
            if (M_AXI_WVALID && M_AXI_WREADY) wBeats++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) arBeats++;
        end
    end

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb);
        CREQ_VALID = valid;
        CREQ_WRITE = write;
        CREQ_ADDR  = addr;
        CREQ_WDATA = wdata;
        CREQ_WSTRB = wstrb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        int awBase;
        int wBase;
        int arBase;

        CRST = 1'b1;
        CRESP_READY = 1'b0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = 32'h0;
        M_AXI_RRESP = 2'b00;
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_creq_ready", 32'(CREQ_READY), 32'd1);
        checkOutput("rst_cbusy", 32'(CBUSY), 32'd0);
        checkOutput("rst_cresp_valid", 32'(CRESP_VALID), 32'd0);
        checkOutput("rst_cresp_rdata", CRESP_RDATA, 32'd0);
        checkOutput("rst_cresp_err", 32'(CRESP_ERR), 32'd0);
        checkOutput("rst_valids", {29'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
        checkOutput("rst_readys", {30'd0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
        checkOutput("rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
        checkOutput("rst_araddr", 32'(M_AXI_ARADDR), 32'd0);
        checkOutput("rst_wdata", M_AXI_WDATA, 32'd0);
        checkOutput("rst_wstrb", 32'(M_AXI_WSTRB), 32'd0);
        CRST = 1'b0;
        tick();

        $display("[TB] basic write");
        applyStimulus(1'b1, 1'b1, 16'h0004, 32'h0000_0001, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        checkOutput("wr_awvalid", 32'(M_AXI_AWVALID), 32'd1);
        checkOutput("wr_wvalid", 32'(M_AXI_WVALID), 32'd1);
        checkOutput("wr_awaddr", 32'(M_AXI_AWADDR), 32'h0004);
        checkOutput("wr_wdata", M_AXI_WDATA, 32'h1);
        checkOutput("wr_wstrb", 32'(M_AXI_WSTRB), 32'hF);
        checkOutput("wr_prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
        checkOutput("wr_creq_ready", 32'(CREQ_READY), 32'd0);
        checkOutput("wr_cbusy", 32'(CBUSY), 32'd1);
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY = 1'b0;
        checkOutput("wr_aw_w_cleared", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
        checkOutput("wr_bready", 32'(M_AXI_BREADY), 32'd1);
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP = 2'b00;
        tick();
        M_AXI_BVALID = 1'b0;
        checkOutput("wr_cresp_valid", 32'(CRESP_VALID), 32'd1);
        checkOutput("wr_cresp_err", 32'(CRESP_ERR), 32'd0);
        checkOutput("wr_cresp_rdata", CRESP_RDATA, 32'd0);
        checkOutput("wr_bready_clr", 32'(M_AXI_BREADY), 32'd0);
        CRESP_READY = 1'b1;
        tick();
        CRESP_READY = 1'b0;
        checkOutput("wr_done_cresp_valid", 32'(CRESP_VALID), 32'd0);
        checkOutput("wr_done_creq_ready", 32'(CREQ_READY), 32'd1);
        checkOutput("wr_done_cbusy", 32'(CBUSY), 32'd0);

        $display("[TB] basic read");
        arBase = arBeats;
        applyStimulus(1'b1, 1'b0, 16'h0008, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        checkOutput("rd_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        checkOutput("rd_araddr", 32'(M_AXI_ARADDR), 32'h0008);
        checkOutput("rd_no_aw", 32'(M_AXI_AWVALID), 32'd0);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        checkOutput("rd_arvalid_clr", 32'(M_AXI_ARVALID), 32'd0);
        checkOutput("rd_rready", 32'(M_AXI_RREADY), 32'd1);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = 32'h0000_00A5;
        M_AXI_RRESP = 2'b00;
        tick();
        M_AXI_RVALID = 1'b0;
        checkOutput("rd_cresp_valid", 32'(CRESP_VALID), 32'd1);
        checkOutput("rd_cresp_rdata", CRESP_RDATA, 32'h0000_00A5);
        checkOutput("rd_cresp_err", 32'(CRESP_ERR), 32'd0);
        checkOutput("rd_rready_clr", 32'(M_AXI_RREADY), 32'd0);
        checkOutput("rd_ar_beats", 32'(arBeats - arBase), 32'd1);
        CRESP_READY = 1'b1;
        tick();
        CRESP_READY = 1'b0;
        checkOutput("rd_done_creq_ready", 32'(CREQ_READY), 32'd1);

        $display("[TB] skewed write");
        awBase = awBeats;
        wBase = wBeats;
        applyStimulus(1'b1, 1'b1, 16'h0012, 32'h1234_5678, 4'h3);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        checkOutput("sk_awaddr", 32'(M_AXI_AWADDR), 32'h0010);
        M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_WREADY = 1'b0;
        checkOutput("sk_wvalid_clr", 32'(M_AXI_WVALID), 32'd0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("sk_awvalid_hold", 32'(M_AXI_AWVALID), 32'd1);
            checkOutput("sk_awaddr_hold", 32'(M_AXI_AWADDR), 32'h0010);
            checkOutput("sk_bready_low", 32'(M_AXI_BREADY), 32'd0);
            tick();
        end
        M_AXI_AWREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        checkOutput("sk_awvalid_clr", 32'(M_AXI_AWVALID), 32'd0);
        checkOutput("sk_bready", 32'(M_AXI_BREADY), 32'd1);
        checkOutput("sk_aw_beats", 32'(awBeats - awBase), 32'd1);
        checkOutput("sk_w_beats", 32'(wBeats - wBase), 32'd1);
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP = 2'b10;
        tick();
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP = 2'b00;
        checkOutput("sk_cresp_err", 32'(CRESP_ERR), 32'd2);
        checkOutput("sk_cresp_valid", 32'(CRESP_VALID), 32'd1);
        CRESP_READY = 1'b1;
        tick();
        CRESP_READY = 1'b0;
        checkOutput("sk_done_creq_ready", 32'(CREQ_READY), 32'd1);

        $display("[TB] response backpressure");
        arBase = arBeats;
        applyStimulus(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = 32'hDEAD_BEEF;
        tick();
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = 32'h0;
        applyStimulus(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_cresp_valid", 32'(CRESP_VALID), 32'd1);
            checkOutput("bp_cresp_rdata", CRESP_RDATA, 32'hDEAD_BEEF);
            checkOutput("bp_creq_ready", 32'(CREQ_READY), 32'd0);
            checkOutput("bp_arvalid", 32'(M_AXI_ARVALID), 32'd0);
            tick();
        end
        checkOutput("bp_ar_beats", 32'(arBeats - arBase), 32'd1);

        $display("[TB] unaligned read with SLVERR, no overlap with response");
        applyStimulus(1'b1, 1'b0, 16'h0006, 32'h0, 4'h0);
        CRESP_READY = 1'b1;
        tick();
        CRESP_READY = 1'b0;
        checkOutput("ov_creq_ready", 32'(CREQ_READY), 32'd1);
        checkOutput("ov_no_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        checkOutput("er_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        checkOutput("er_araddr", 32'(M_AXI_ARADDR), 32'h0004);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = 32'h0000_0011;
        M_AXI_RRESP = 2'b10;
        tick();
        M_AXI_RVALID = 1'b0;
        M_AXI_RRESP = 2'b00;
        checkOutput("er_cresp_err", 32'(CRESP_ERR), 32'd2);
        checkOutput("er_cresp_rdata", CRESP_RDATA, 32'h0000_0011);
        CRESP_READY = 1'b1;
        tick();
        CRESP_READY = 1'b0;
        checkOutput("er_idle_creq_ready", 32'(CREQ_READY), 32'd1);
        checkOutput("er_idle_cbusy", 32'(CBUSY), 32'd0);

        $display("[TB] early RVALID then reset mid-read");
        applyStimulus(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = 32'h0000_0055;
        tick();
        checkOutput("ea_arvalid_hold", 32'(M_AXI_ARVALID), 32'd1);
        checkOutput("ea_rready_low", 32'(M_AXI_RREADY), 32'd0);
        checkOutput("ea_cresp_valid", 32'(CRESP_VALID), 32'd0);
        CRST = 1'b1;
        tick();
        CRST = 1'b0;
        M_AXI_RVALID = 1'b0;
        checkOutput("mr_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        checkOutput("mr_cbusy", 32'(CBUSY), 32'd0);
        checkOutput("mr_creq_ready", 32'(CREQ_READY), 32'd1);
        checkOutput("mr_cresp_valid", 32'(CRESP_VALID), 32'd0);
        checkOutput("mr_araddr", 32'(M_AXI_ARADDR), 32'd0);
        tick();
        checkOutput("mr_idle_hold", {30'd0, CREQ_READY, M_AXI_RREADY}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_axi_master.md
Name: core_axi_master

Overview:
- AXI4-Lite initiator used by the core to issue single-beat register and memory accesses to AXI4-Lite slaves, including core_controller register banks.
- Converts a simple valid/ready request/response pair on the core side into one AXI4-Lite read or write transaction at a time.
- Sits between core logic and the AXI interconnect, entirely in the CCLK domain.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 16, AXI address width.

Ports:
- CCLK  in  1  single clock for the core side and the AXI side.
- CRST  in  1  synchronous, active-high reset.
- CREQ_VALID  in  1  core request valid.
- CREQ_READY  out  1  master idle; request accepted when CREQ_VALID & CREQ_READY.
- CREQ_WRITE  in  1  1 = write, 0 = read.
- CREQ_ADDR  in  ADDR_WIDTH  byte address.
- CREQ_WDATA  in  32  write data.
- CREQ_WSTRB  in  4  write byte strobes.
- CRESP_VALID  out  1  response valid.
- CRESP_READY  in  1  core accepts response.
- CRESP_RDATA  out  32  read data; 0 for writes.
- CRESP_ERR  out  2  captured BRESP or RRESP.
- CBUSY  out  1  high in every state except IDLE.
- M_AXI_AWADDR/AWPROT(3)/AWVALID out, M_AXI_AWREADY in.
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in.
- M_AXI_BRESP(2)/BVALID in, M_AXI_BREADY out.
- M_AXI_ARADDR/ARPROT(3)/ARVALID out, M_AXI_ARREADY in.
- M_AXI_RDATA/RRESP(2)/RVALID in, M_AXI_RREADY out.

Behaviour:
- All outputs are registered. No AXI VALID depends combinationally on any READY.
- Reset values: CREQ_READY=1 (state IDLE). All AXI VALID and READY outputs, CRESP_VALID, CRESP_RDATA, CRESP_ERR, CBUSY, AxADDR, WDATA and WSTRB are 0.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - CREQ_READY=1.
  - On accept: latch address, data and strobes; CREQ_READY drops the next cycle.
  - CREQ_WRITE=1: go to WRITE, asserting AWVALID and WVALID together.
  - CREQ_WRITE=0: go to RADDR, asserting ARVALID.
- Address alignment: AxADDR = CREQ_ADDR with bits [1:0] forced to 0. AxPROT = 3'b000.
- WRITE:
  - AW and W complete independently. AWVALID clears the cycle after AWVALID & AWREADY; WVALID clears the cycle after WVALID & WREADY.
  - Flags aw_done and w_done record completion. Both handshakes in the same cycle is legal.
  - When both are done, go to WRESP with BREADY=1.
- WRESP: on BVALID & BREADY, capture BRESP into CRESP_ERR, set CRESP_RDATA=0, clear BREADY, go to RESP.
- RADDR: ARVALID held until ARVALID & ARREADY, then ARVALID=0, RREADY=1, go to RDATA.
- RDATA: on RVALID & RREADY, capture RDATA and RRESP, clear RREADY, go to RESP.
- RESP:
  - CRESP_VALID=1, held with stable data until CRESP_READY.
  - On CRESP_VALID & CRESP_READY, return to IDLE; CREQ_READY=1 the next cycle.
  - A new request cannot be accepted in the same cycle as a response (no overlap).
- VALID stability: once asserted, AWVALID, WVALID and ARVALID and their payloads hold unchanged until the handshake, regardless of how long READY stays low. There is no timeout.
- An early BVALID or RVALID (before the master is in WRESP or RDATA) is not acknowledged until the master reaches that state.
- Errors: SLVERR (2) and DECERR (3) are reported via CRESP_ERR only; no retry, and the FSM proceeds normally.
- CRST mid-transaction: immediate return to the reset values. The system ties the slave and interconnect resets to the same source, so abandoning a transfer is safe.
- CREQ_* inputs are ignored outside IDLE.

Test Plan:
- Write: addr 0x0004, data 0x0000_0001, strb 0xF; slave asserts AWREADY and WREADY one cycle after both valids, BVALID the following cycle -> AWADDR=0x0004 and WDATA=1 seen; CRESP_VALID with CRESP_ERR=0; CREQ_READY back to 1 the cycle after CRESP_READY.
- Read: addr 0x0008, slave returns RDATA=0x0000_00A5, RRESP=0 -> CRESP_RDATA=0xA5, CRESP_ERR=0; ARVALID high for exactly one cycle beyond ARREADY latency.
- Skewed write: WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID holds; BREADY rises only after both complete; exactly one AW and one W beat.
- Backpressure: CRESP_READY held low 5 cycles with read data 0xDEAD_BEEF -> CRESP_VALID and CRESP_RDATA stable for all 5 cycles; no new AR issued; CREQ_READY=0 throughout.
- Error and alignment: read of unaligned addr 0x0006 with slave RRESP=2 -> ARADDR=0x0004, CRESP_ERR=2, FSM returns to IDLE.
- Reset mid-op: CRST asserted while ARVALID=1 -> next cycle ARVALID=0, CBUSY=0, CREQ_READY=1, CRESP_VALID=0.
